// File: rtl/rd_stream_out.sv
// rd_stream_out: read-side output stage of the async FIFO.
//
// Issues pop requests (rd_inc) to the read pointer block, captures the FIFO
// memory read data and presents it as a valid/ready stream in the read clock
// domain. A small circular output buffer absorbs the memory read latency and
// consumer backpressure, sustaining one word per cycle while the FIFO is
// non-empty and the consumer is ready.
//
// Parameters:
//   DATA_SIZE  width of a FIFO data word
//   RD_LAT     memory read latency in rd_clk cycles (0 or 1)
//   BUF_DEPTH  output buffer entries; needs >= RD_LAT+1 for full throughput
//
// Ports:
//   rd_clk     read-domain clock
//   rd_rst     asynchronous reset, active-high
//   rd_empty   registered empty flag from the read pointer block
//   rd_inc     pop request to the read pointer block
//   rd_data    FIFO memory read data
//   out_valid  out_data holds a valid word
//   out_ready  consumer accepts the word this cycle
//   out_data   head word of the output buffer
//   out_count  words currently held in the buffer
module rd_stream_out #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                               rd_clk,
    input  logic                               rd_rst,
    input  logic                               rd_empty,
    output logic                               rd_inc,
    input  logic [DATA_SIZE-1:0]               rd_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_SIZE-1:0]               out_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     out_count
);

    localparam int unsigned CntW  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned IdxW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // One extra bit so occ + inflight never wraps before the capacity compare.
    localparam int unsigned PendW = CntW + 1;
    localparam logic [PendW-1:0] DepthP  = PendW'(BUF_DEPTH);
    localparam logic [IdxW-1:0]  LastIdx = IdxW'(BUF_DEPTH - 1);

    logic [DATA_SIZE-1:0] mem_q [BUF_DEPTH];
    logic [IdxW-1:0]      head_q, head_d;
    logic [IdxW-1:0]      tail_q, tail_d;
    logic [CntW-1:0]      occ_q, occ_d;
    logic                 inflight_q, inflight_d;

    logic                 deq;
    logic                 pop;
    logic                 wr;
    logic [PendW-1:0]     pending;

    function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
        return (idx == LastIdx) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        deq     = (occ_q != '0) & out_ready;
        // Slots committed after this cycle's dequeue; a slot freed by deq can
        // be re-requested in the same cycle.
        pending = PendW'(occ_q) + PendW'(inflight_q) - PendW'(deq);
        rd_inc  = ~rd_rst & (pending < DepthP);
        pop     = rd_inc & ~rd_empty;

        if (RD_LAT == 0) begin
            // Read data is valid in the pop cycle; capture it directly.
            wr         = pop;
            inflight_d = 1'b0;
        end else begin
            // Read data arrives one cycle after the pop.
            wr         = inflight_q;
            inflight_d = pop;
        end

        occ_d  = occ_q + CntW'(wr) - CntW'(deq);
        head_d = deq ? next_idx(head_q) : head_q;
        tail_d = wr  ? next_idx(tail_q) : tail_q;
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (wr) begin
                mem_q[tail_q] <= rd_data;
            end
        end
    end

    // Outputs come straight from registers: no rd_data-to-out_data bypass.
    assign out_valid = (occ_q != '0);
    assign out_data  = mem_q[head_q];
    assign out_count = occ_q;

endmodule
